// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for alu_seq and the decode logic that drives it.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned MUL / DIVU / REMU engine, one iteration per clock over WIDTH cycles.
// Only built when ALU_SEQ_MULDIV_EN is defined.
`ifdef ALU_SEQ_MULDIV_EN
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  import alu_seq_pkg::*;

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic             is_mul;
  logic             rem_sel;
  // acc: product (MUL) or partial remainder (DIV); x: multiplicand or dividend/quotient; y: multiplier or divisor
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] x, x_nxt;
  logic [WIDTH-1:0] y, y_nxt;
  logic [WIDTH:0]   trial, diff;

  always_comb begin
    trial   = {acc, x[WIDTH-1]};
    diff    = trial - {1'b0, y};
    acc_nxt = acc;
    x_nxt   = x;
    y_nxt   = y;
    if (is_mul) begin
      if (y[0]) acc_nxt = acc + x;
      x_nxt = x << 1;
      y_nxt = y >> 1;
    end else if (!diff[WIDTH]) begin
      acc_nxt = diff[WIDTH-1:0];
      x_nxt   = {x[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = trial[WIDTH-1:0];
      x_nxt   = {x[WIDTH-2:0], 1'b0};
    end
  end

  // Divide by zero needs no special case: every trial subtract succeeds, giving all-ones / a.
  assign done   = busy && (cnt == '0);
  assign result = (is_mul || rem_sel) ? acc_nxt : x_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      is_mul  <= 1'b0;
      rem_sel <= 1'b0;
      acc     <= '0;
      x       <= '0;
      y       <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= CW'(WIDTH - 1);
      is_mul  <= (op == OP_MUL);
      rem_sel <= (op == OP_REMU);
      acc     <= '0;
      x       <= a;
      y       <= b;
    end else if (busy) begin
      acc <= acc_nxt;
      x   <= x_nxt;
      y   <= y_nxt;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/shift/add/compare ops inline, iterative MUL/DIVU/REMU
// through alu_seq_muldiv when ALU_SEQ_MULDIV_EN is defined (otherwise those codes are illegal).
//
// state   | meaning
// IDLE    | in_ready high, waiting for in_valid
// BUSY    | iterative mul/div in progress
// DONE    | out_valid high, result held until out_ready
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);
  import alu_seq_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sc_result;
  logic             sc_illegal;
  logic             wr_en;
  logic [WIDTH-1:0] wr_result;
  logic             wr_illegal;
  logic [SHW-1:0]   shamt;

  assign shamt = b[SHW-1:0];

  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (alu_control)
      OP_ADD:  sc_result = a + b;
      OP_SUB:  sc_result = a - b;
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_XOR:  sc_result = a ^ b;
      OP_SLL:  sc_result = a << shamt;
      OP_SRL:  sc_result = a >> shamt;
      OP_SRA:  sc_result = $signed(a) >>> shamt;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, a < b};
      default: sc_illegal = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op     (alu_control),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );
`endif

  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    wr_result  = sc_result;
    wr_illegal = sc_illegal;
`ifdef ALU_SEQ_MULDIV_EN
    md_start   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
          if (is_muldiv(alu_control)) begin
            md_start = 1'b1;
            state_d  = ST_BUSY;
          end else
`endif
          begin
            wr_en   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      ST_BUSY: begin
        if (md_done) begin
          wr_en      = 1'b1;
          wr_result  = md_result;
          wr_illegal = 1'b0;
          state_d    = ST_DONE;
        end
      end
`endif
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en) begin
        result  <= wr_result;
        zero    <= (wr_result == '0);
        illegal <= wr_illegal;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Registers operands on accept and computes the logic, shift, add and compare ops in one cycle.
- Adds unsigned multiply and divide/remainder, each iterated over WIDTH cycles.
- Sits between decode/issue and writeback; valid/ready on both sides lets the core stall on long ops.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 8 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width taken from B[SHW-1:0]; derived, not to be overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu_control  input  4  opcode.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- zero  output  1  registered flag: result == 0.
- illegal  output  1  registered flag: opcode not supported.

Behaviour:
- Opcodes:
  - 0010 ADD; 0110 SUB; 0000 AND; 0001 OR; 0011 XOR.
  - 0100 SLL, 0101 SRL, 0111 SRA; shift amount is B[SHW-1:0].
  - 1000 SLT (signed); 1001 SLTU.
  - 1010 MUL: low WIDTH bits of the product.
  - 1011 DIVU; 1100 REMU.
  - All other codes are illegal.
- FSM states IDLE, BUSY, DONE. Reset forces IDLE.
- Reset values: result=0, zero=0, illegal=0, out_valid=0, counter=0, operand registers=0.
- in_ready = (state==IDLE); it is a registered-state decode only, with no combinational path from out_ready.
- Accept: in_valid && in_ready.
  - Latches a, b and alu_control.
  - Single-cycle or illegal op: compute, go to DONE next edge. out_valid is seen 1 cycle after accept.
  - MUL/DIVU/REMU: go to BUSY with counter=WIDTH-1.
- BUSY:
  - One iteration per clock.
  - MUL uses shift-add over the multiplier bits, keeping a WIDTH-bit product.
  - DIVU/REMU use a restoring shift-subtract with a WIDTH+1-bit partial remainder.
  - On the last iteration (counter==0) write result and go to DONE. out_valid is seen WIDTH+1 cycles after accept.
- DONE:
  - out_valid=1; result, zero and illegal hold stable until out_valid && out_ready.
  - On that handshake go to IDLE. in_ready rises the next cycle; there is no back-to-back overlap.
- Divide by zero (b==0): DIVU returns all-ones; REMU returns a. Full WIDTH cycles are still taken, so latency is data-independent.
- Illegal opcode: result=0, zero=1, illegal=1, 1-cycle latency.
- zero and illegal update only when result is written.
- Arithmetic wraps modulo 2^WIDTH; SUB and SLT use two's complement.
- Reset asserted in any state aborts the operation and returns to IDLE with reset values.
- in_valid while not in IDLE is ignored; the request must be held by the source.
- a, b and alu_control are sampled only on accept, so later input changes do not affect the op in flight.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined:
  - MUL/DIVU/REMU are supported as above, and BUSY state plus counter exist.
- Undefined:
  - Iterative datapath and BUSY are not built.
  - Codes 1010/1011/1100 are illegal (result=0, zero=1, illegal=1, 1-cycle latency).
  - Every op completes in 1 cycle.

Decomposition:
- Package alu_seq_pkg holds the 4-bit opcode localparams (OP_ADD ... OP_REMU) and the FSM state enum typedef.
- alu_control generators in decode import the package.
- One natural sub-module: alu_seq_muldiv, the iterative MUL/DIV engine.
  - Inputs: start, op, a, b.
  - Outputs: done, result.
  - Guarded by ALU_SEQ_MULDIV_EN.
- The single-cycle ops stay inline in alu_seq.

Test Plan:
- Reset: hold reset 3 cycles mid-BUSY (DIVU in flight) -> next cycle in_ready=1, out_valid=0, result=0, illegal=0.
- Single-cycle ops, WIDTH=32, out_ready=1:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, 1-cycle latency.
  - SUB 5-5 -> 0, zero=1.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SLT -1<1 -> 1; SLTU -1<1 -> 0.
- Multi-cycle ops, WIDTH=32:
  - MUL 0x10000×0x10000 -> 0 with zero=1, out_valid exactly 33 cycles after accept.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; latency 33 cycles.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with a/b/alu_control toggling -> result stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
- Illegal opcode 1111 -> result=0, zero=1, illegal=1. Without ALU_SEQ_MULDIV_EN, 1010 -> illegal=1 at 1-cycle latency.
